// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    // One buffered fetch result: the word and the PC it was fetched from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // RUN: no stale responses pending. DRAIN: dropping responses from before a redirect.
    typedef enum logic [0:0] {
        RUN,
        DRAIN
    } fetch_state_e;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    // Force a byte address onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with flush and occupancy count.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  fetch_entry_t             wdata,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_entry_t             rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop_en;

    // Popping an empty FIFO is a no-op rather than a pointer corruption.
    assign pop_en = pop && (count_q != '0);
    assign rdata  = mem_q[rd_ptr_q];
    assign count  = count_q;

    // Pointer and occupancy next-state; flush wins over push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_en) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop_en);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset since count gates validity.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // The upstream credit scheme must never overfill the buffer.
    assert property (@(posedge clk) disable iff (rst) !(push && !flush && count_q == FULL));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC generation, request credit, response buffering, redirect drain.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_SUM = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    fetch_state_e  state_q, state_d;

    logic [CW-1:0] fifo_count;
    logic [CW:0]   credit_used;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;
    logic          grant;
    logic          push;
    logic          pop;

    // Buffered words plus in-flight requests may never exceed the buffer size,
    // so every response is guaranteed a slot.
    assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding_q};
    assign imem_req    = !rst && !redirect_valid && (credit_used < DEPTH_SUM);
    assign imem_addr   = fetch_pc_q;
    assign grant       = imem_req && imem_gnt;

    assign push       = imem_rvalid && (discard_q == '0) && !redirect_valid;
    assign push_entry = '{pc: resp_pc_q, instr: imem_rdata};

    assign instr_valid = (fifo_count != '0);
    assign pop         = instr_valid && instr_ready && !redirect_valid;
    assign instr       = instr_valid ? head.instr : '0;
    assign instr_pc    = instr_valid ? head.pc : '0;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .flush (redirect_valid),
        .rdata (head),
        .count (fifo_count)
    );

    // PC, credit and discard bookkeeping; a redirect overrides everything.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        discard_d     = discard_q;
        outstanding_d = outstanding_q + CW'(grant) - CW'(imem_rvalid);
        if (redirect_valid) begin
            fetch_pc_d = word_align(redirect_pc);
            resp_pc_d  = word_align(redirect_pc);
            // Everything still in flight after this cycle belongs to the old path.
            discard_d  = outstanding_q - CW'(imem_rvalid);
        end else begin
            if (grant) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (imem_rvalid) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - CW'(1);
                end else begin
                    resp_pc_d = resp_pc_q + 32'd4;
                end
            end
        end
    end

    // Drain FSM next state, tracking whether stale responses remain.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (discard_d != '0) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (discard_d == '0) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            state_q       <= RUN;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            state_q       <= state_d;
        end
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage, directly upstream of the single-cycle decode/execute core (control, sign extension, register file/ALU).
- Owns the fetch PC and issues word requests to instruction memory over a req/gnt/rvalid interface.
- Buffers returned words with their PCs in a small FIFO and presents them downstream on a valid/ready handshake.
- A taken branch/jump from the core redirects fetch, flushes buffered words and discards in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
DEPTH, 2, FIFO entries and maximum outstanding memory requests (power of two, >=2)

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  asynchronous active-high reset
imem_req  output  1  request valid
imem_addr  output  32  word address (bits[1:0] always 0)
imem_gnt  input  1  request accepted this cycle
imem_rvalid  input  1  response valid (in order, >=1 cycle after gnt)
imem_rdata  input  32  instruction word
instr_valid  output  1  instr/instr_pc valid
instr  output  32  instruction to decode
instr_pc  output  32  PC of instr
instr_ready  input  1  core accepts instruction
redirect_valid  input  1  taken branch/jump (one-cycle pulse)
redirect_pc  input  32  new PC; bits[1:0] ignored, treated as 0

Behaviour:
Clock and reset:
- One clock (clk). Reset (rst) is asynchronous, active-high.
- On rst: fetch_pc=RESET_PC, resp_pc=RESET_PC, FIFO count=0, outstanding=0, discard=0, state=RUN.
- All outputs 0 while reset is asserted, except imem_addr=RESET_PC.
- Instruction memory must be reset together with this block; pre-reset responses are not tolerated.

Request issue:
- imem_req=1 iff !redirect_valid && (count+outstanding < DEPTH).
- imem_addr=fetch_pc.
- On req&&gnt: fetch_pc+=4 (wraps modulo 2^32); outstanding+=1.
- No timeout on gnt.

Responses:
- On rvalid: outstanding-=1.
- If discard>0: word is dropped and discard-=1.
- Otherwise: push {resp_pc, rdata}, then resp_pc+=4.
- Credit rule guarantees the FIFO is never full on push. A push into a full FIFO is an assertion failure.

Output:
- instr_valid = (count!=0); instr/instr_pc come from the FIFO head.
- Pop on instr_valid&&instr_ready.
- Push and pop in the same cycle leave count unchanged.
- Empty FIFO: instr_valid=0 and head data are don't-care.
- Fall-through latency: a word received at edge N is visible after edge N, i.e. rvalid->instr_valid is 1 cycle.

Redirect (highest priority):
- FIFO cleared; any simultaneous pop/push is ignored.
- fetch_pc <= {redirect_pc[31:2],2'b00}; resp_pc <= the same value.
- discard <= outstanding - (rvalid ? 1 : 0), i.e. every in-flight response is dropped.
- No request is issued in the redirect cycle; issue resumes the next cycle.
- A second redirect during DRAIN recomputes discard with the same rule.

FSM:
- RUN: discard==0. Goes to DRAIN when a redirect leaves discard>0.
- DRAIN: discard>0. New requests are still issued. Returns to RUN when discard reaches 0.

Decomposition:
- Package fetch_pkg:
  - typedef fetch_entry_t packed struct {logic [31:0] pc; logic [31:0] instr;}
  - typedef fetch_state_e {RUN, DRAIN}
  - localparam INSTR_NOP = 32'h0000_0013
- Sub-module fetch_fifo: parameterised DEPTH synchronous FIFO of fetch_entry_t with push/pop/flush and count output; async reset.
- fetch_unit holds the PC/credit/discard logic and the FSM.

Test Plan:
- Reset, gnt=1, rvalid exactly 1 cycle after each gnt, ready=1 → instr_pc sequence 0,4,8,12 with matching rdata; at most 2 outstanding.
- ready=0 for 10 cycles → after 2 grants imem_req=0 and instr_valid=1 holds PC 0; release ready → 0,4 delivered, fetching resumes at 8.
- 2 requests outstanding, redirect_valid with redirect_pc=32'h100 → both responses dropped, FSM in DRAIN; next delivered instr_pc=0x100.
- Redirect in the same cycle as rvalid with 1 outstanding → that word dropped, discard=0, state stays RUN; redirect_pc=0x203 yields instr_pc=0x200.
- gnt held low 5 cycles → imem_addr stable and no PC advance; then fetch_pc=32'hFFFF_FFFC granted → next imem_addr=0.
- rst asserted asynchronously mid-DRAIN → instr_valid and imem_req drop immediately; after release, fetch restarts at RESET_PC with count=0.
